// File: rtl/cache_axi_rd_bridge_if.sv
// Signal bundle between the cache refill port, the bridge and the AXI4 read channels.
// The master modport is the bridge's view; the slave modport is the cache/AXI environment's view.
interface cache_axi_rd_bridge_if;
    logic        r_req;
    logic [31:0] r_addr;
    logic        r_rdy;
    logic        r_data_ready;
    logic        ret_valid;
    logic [31:0] ret_data;
    logic        ret_last;
    logic        rd_err;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  r_req, r_addr, r_data_ready, arready, rid, rdata, rresp, rlast, rvalid,
        output r_rdy, ret_valid, ret_data, ret_last, rd_err,
               arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport slave (
        output r_req, r_addr, r_data_ready, arready, rid, rdata, rresp, rlast, rvalid,
        input  r_rdy, ret_valid, ret_data, ret_last, rd_err,
               arid, araddr, arlen, arsize, arburst, arvalid, rready
    );
endinterface

// File: rtl/cache_axi_rd_bridge.sv
// Cache line refill to single-outstanding AXI4 INCR read burst; AR issued the cycle after accept.
// R beats pass through combinationally with rready = r_data_ready, so the cache backpressures AXI directly.
module cache_axi_rd_bridge #(
    parameter int unsigned LINE_WORDS = 16,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic                  clk,
    input  logic                  rstn,
    cache_axi_rd_bridge_if.master bus
);
    localparam int unsigned   OFF       = $clog2(LINE_WORDS * 4);
    localparam int unsigned   CW        = $clog2(LINE_WORDS) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_req_rdy, w_req_rdy_nxt;
    logic [31:0]   r_addr, w_addr_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_err, w_err_nxt;
    logic          r_err_pulse, w_err_pulse_nxt;

    logic          w_arvalid;
    logic          w_rready;
    logic          w_ret_valid;
    logic          w_ret_last;
    logic          w_beat;
    logic          w_beat_bad;
    logic          w_at_last;
    logic          w_unused_addr_lsb;

    assign w_at_last         = (r_cnt == LAST_BEAT);
    assign w_unused_addr_lsb = ^bus.r_addr[OFF-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_req_rdy   <= 1'b0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_req_rdy   <= w_req_rdy_nxt;
            r_addr      <= w_addr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_err_pulse <= w_err_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_req_rdy_nxt   = r_req_rdy;
        w_addr_nxt      = r_addr;
        w_cnt_nxt       = r_cnt;
        w_err_nxt       = r_err;
        w_err_pulse_nxt = 1'b0;
        w_arvalid       = 1'b0;
        w_rready        = 1'b0;
        w_ret_valid     = 1'b0;
        w_ret_last      = 1'b0;
        w_beat          = 1'b0;
        w_beat_bad      = 1'b0;

        case (r_state)
            IDLE: begin
                // r_rdy is held low for the first cycle after reset, so the request is only seen once it is high
                w_req_rdy_nxt = 1'b1;
                if (bus.r_req && r_req_rdy) begin
                    w_req_rdy_nxt = 1'b0;
                    w_addr_nxt    = {bus.r_addr[31:OFF], {OFF{1'b0}}};
                    w_cnt_nxt     = '0;
                    w_state_nxt   = AR;
                end
            end
            AR: begin
                w_arvalid = 1'b1;
                if (bus.arready) begin
                    w_state_nxt = R;
                end
            end
            R: begin
                w_rready    = bus.r_data_ready;
                w_ret_valid = bus.rvalid;
                w_ret_last  = bus.rvalid && w_at_last;
                w_beat      = bus.rvalid && bus.r_data_ready;
                // Beat count, not rlast, ends the burst; a disagreeing rlast is reported as an error
                w_beat_bad  = (bus.rresp != 2'b00) || (bus.rid != AXI_ID) || (bus.rlast != w_at_last);
                if (w_beat) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (w_at_last) begin
                        w_state_nxt     = IDLE;
                        w_req_rdy_nxt   = 1'b1;
                        w_err_pulse_nxt = r_err || w_beat_bad;
                        w_err_nxt       = 1'b0;
                    end else if (w_beat_bad) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.r_rdy     = r_req_rdy;
    assign bus.rd_err    = r_err_pulse;
    assign bus.arvalid   = w_arvalid;
    assign bus.araddr    = r_addr;
    assign bus.arlen     = 8'(LINE_WORDS - 1);
    assign bus.arsize    = 3'b010;
    assign bus.arburst   = 2'b01;
    assign bus.arid      = AXI_ID;
    assign bus.rready    = w_rready;
    assign bus.ret_valid = w_ret_valid;
    assign bus.ret_last  = w_ret_last;
    assign bus.ret_data  = bus.rdata;
endmodule

// File: doc/cache_axi_rd_bridge.md
CACHE_AXI_RD_BRIDGE -- requirements
Module: cache_axi_rd_bridge

Interface
REQ-001 Parameter LINE_WORDS, default 16: 32-bit words per cache line refill; power of two, 2..256.
REQ-002 Parameter AXI_ID, default 4'd0: constant value driven on arid.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rstn  input  1  reset; asynchronous and active-low.
REQ-005 r_req  input  1  cache requests a line refill.
REQ-006 r_addr  input  32  byte address of the refill request.
REQ-007 r_rdy  output  1  bridge ready to accept a refill request.
REQ-008 r_data_ready  input  1  cache accepts the presented return beat.
REQ-009 ret_valid  output  1  return beat valid.
REQ-010 ret_data  output  32  return beat data.
REQ-011 ret_last  output  1  final beat of the line.
REQ-012 rd_err  output  1  one-cycle pulse: the refill saw an error.
REQ-013 arid, araddr, arlen, arsize, arburst, arvalid  output  4/32/8/3/2/1  AXI4 read-address channel.
REQ-014 arready  input  1  AXI read-address channel handshake.
REQ-015 rid, rdata, rresp, rlast, rvalid  input  4/32/2/1/1  AXI4 read-data channel.
REQ-016 rready  output  1  AXI read-data channel handshake.

Function
REQ-017 The block SHALL use exactly three states: IDLE, AR, R.
REQ-018 IDLE: registered r_rdy=1; r_req&&r_rdy SHALL latch {r_addr[31:log2(LINE_WORDS*4)], zeros} into the address register, clear r_rdy, clear the beat counter and go to AR next cycle.
REQ-019 IDLE: r_req while r_rdy=0 (first cycle after reset release) SHALL be ignored; the cache holds r_req until the request is accepted.
REQ-020 AR: arvalid=1 with araddr=latched aligned address, arlen=LINE_WORDS-1, arsize=3'b010, arburst=2'b01 (INCR), arid=AXI_ID; all SHALL stay stable until arready.
REQ-021 AR: arvalid&&arready SHALL clear arvalid and go to R next cycle; arready while arvalid=0 SHALL be ignored.
REQ-022 R: rready SHALL equal r_data_ready; ret_valid SHALL equal rvalid; ret_data SHALL equal rdata (combinational pass-through; zero added latency).
REQ-023 A beat SHALL be accepted only when rvalid&&rready; each accepted beat SHALL increment the beat counter (width log2(LINE_WORDS)+1).
REQ-024 ret_last SHALL be 1 iff in R with ret_valid=1 and beat counter == LINE_WORDS-1; it SHALL be derived from the counter, never from rlast.
REQ-025 On acceptance of beat LINE_WORDS-1, the FSM SHALL return to IDLE and set r_rdy=1 on the same edge; a new r_req SHALL be accepted no earlier than the following cycle.
REQ-026 An error flag SHALL be set on any accepted beat with rresp!=2'b00, rid!=AXI_ID, or rlast mismatched with ret_last; on return to IDLE, rd_err SHALL pulse for exactly one cycle if the flag is set, then the flag clears.
REQ-027 Errors SHALL NOT shorten or extend the burst; all LINE_WORDS beats are still forwarded.
REQ-028 Outside R: rready=0, ret_valid=0, ret_last=0; ret_data is don't-care.
REQ-029 rvalid in IDLE or AR SHALL be ignored (no beat counted, no error).
REQ-030 Only one outstanding AXI transaction SHALL exist at any time.

Reset
REQ-031 rstn low SHALL immediately force state=IDLE, r_rdy=0, arvalid=0, rready=0, ret_valid=0, ret_last=0, rd_err=0, beat counter=0, error flag=0, address register=0.
REQ-032 r_rdy SHALL rise at the first rising clk edge after rstn goes high.
REQ-033 Reset asserted mid-AR or mid-R SHALL abandon the transaction with no rd_err pulse; after release, any leftover AXI beats arriving in IDLE SHALL be ignored per REQ-029.

Verification
REQ-034 Basic refill: r_addr=0x1234_5678, arready on first cycle, 16 back-to-back beats rdata=0..15, r_data_ready=1 -> araddr=0x1234_5640, arlen=15, ret_data 0..15, ret_last only on beat 15, r_rdy=1 on the next cycle, rd_err=0.
REQ-035 Backpressure: r_data_ready toggles 1,0,1,0 -> rready mirrors it, no beat lost or duplicated, counter reaches 15 exactly once.
REQ-036 arready delayed 5 cycles -> arvalid held 5+1 cycles with araddr/arlen stable, no transition to R before the handshake.
REQ-037 rresp=2'b10 on beat 3 -> all 16 beats still forwarded, rd_err=1 for exactly one cycle on return to IDLE.
REQ-038 rstn pulsed low during beat 7 -> all outputs 0 immediately, r_rdy=1 one edge after release, stray rvalid ignored, next refill completes normally.
